skewed_sync_seq: RTL

- Window sequencer for one unary bitstream pair feeding a skewed synchronizer datapath.
- On a start handshake it runs the pair through the synchronizer for exactly `len` cycles, then optionally flushes the ones still held in the synchronizer's counter, then pulses done.
- Reports the emitted ones-count of each output stream.
- Sits between a bitstream generator pair and a downstream unary compute unit that needs correlated, length-bounded streams.

---
 rtl/skewed_sync_pkg.sv | 21 ++
 rtl/skewed_sync_core.sv | 62 ++++++
 rtl/skewed_sync_seq.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/skewed_sync_pkg.sv
// Shared types and helpers for the skewed synchronizer window sequencer.
// Imported by the sequencer top and the synchronizer core.
package skewed_sync_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // A zero length field stands for the full 2^lenw window.
    function automatic logic [31:0] len_decode(
        input logic [31:0] len,
        input int          lenw
    );
        if (len == 32'd0) return 32'd1 << lenw;
        return len;
    endfunction

endpackage

// File: rtl/skewed_sync_core.sv
// Skewed synchronizer: holds unmatched in0 ones in a saturating counter
// and releases them when in1 leads, or during the end-of-window flush.
module skewed_sync_core
    import skewed_sync_pkg::*;
#(
    parameter int DEP = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic flush_i,
    input  logic clr_i,
    input  logic in0_i,
    input  logic in1_i,
    output logic out0_o,
    output logic cnt_empty_o,
    output logic cnt_full_o
);

    logic [DEP-1:0] cnt_q;
    logic [DEP-1:0] cnt_d;

    assign cnt_empty_o = (cnt_q == '0);
    assign cnt_full_o  = &cnt_q;

    // Output rule and next hold count; clear wins over any update.
    always_comb begin
        cnt_d  = cnt_q;
        out0_o = 1'b0;
        if (en_i) begin
            unique case ({in0_i, in1_i})
                2'b10: begin
                    if (cnt_full_o) begin
                        out0_o = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                2'b01: begin
                    if (!cnt_empty_o) begin
                        out0_o = 1'b1;
                        cnt_d  = cnt_q - 1'b1;
                    end
                end
                default: out0_o = in0_i;
            endcase
        end else if (flush_i) begin
            if (!cnt_empty_o) begin
                out0_o = 1'b1;
                cnt_d  = cnt_q - 1'b1;
            end
        end
        if (clr_i) cnt_d = '0;
    end

    // Hold counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/skewed_sync_seq.sv
// Window sequencer: runs a bitstream pair through the skewed synchronizer
// for a bounded length, optionally flushes held ones, and counts outputs.
module skewed_sync_seq
    import skewed_sync_pkg::*;
#(
    parameter int DEP  = 2,
    parameter int LENW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [LENW-1:0] len,
    input  logic            flush_en,
    input  logic            in0,
    input  logic            in1,
    output logic            in_ready,
    output logic            out0,
    output logic            out1,
    output logic            out_valid,
    output logic            busy,
    output logic            done,
    output logic [LENW:0]   ones0,
    output logic [LENW:0]   ones1
);

    seq_state_t    state_q, state_d;
    logic [LENW:0] rem_q, rem_d;
    logic          fe_q, fe_d;
    logic [LENW:0] ones0_q, ones0_d;
    logic [LENW:0] ones1_q, ones1_d;
    logic [LENW:0] rem_load;
    logic          core_en, core_flush, core_clr;
    logic          core_out0, cnt_empty, cnt_full;

    assign rem_load = (LENW+1)'(len_decode(32'(len), LENW));
    assign ones0    = ones0_q;
    assign ones1    = ones1_q;

    skewed_sync_core #(
        .DEP(DEP)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (core_en),
        .flush_i    (core_flush),
        .clr_i      (core_clr),
        .in0_i      (in0),
        .in1_i      (in1),
        .out0_o     (core_out0),
        .cnt_empty_o(cnt_empty),
        .cnt_full_o (cnt_full)
    );

    // Next state, stream outputs and counter updates for the window.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        fe_d       = fe_q;
        ones0_d    = ones0_q;
        ones1_d    = ones1_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out0       = 1'b0;
        out1       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        core_en    = 1'b0;
        core_flush = 1'b0;
        core_clr   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    rem_d    = rem_load;
                    fe_d     = flush_en;
                    ones0_d  = '0;
                    ones1_d  = '0;
                    core_clr = 1'b1;
                end
            end
            RUN: begin
                in_ready  = 1'b1;
                out_valid = 1'b1;
                out0      = core_out0;
                out1      = in1;
                busy      = 1'b1;
                core_en   = 1'b1;
                rem_d     = rem_q - 1'b1;
                if (abort) begin
                    state_d  = IDLE;
                    core_clr = 1'b1;
                end else if (rem_q == (LENW+1)'(1)) begin
                    state_d = fe_q ? FLUSH : DONE;
                end
            end
            FLUSH: begin
                busy       = 1'b1;
                core_flush = 1'b1;
                out_valid  = !cnt_empty;
                out0       = core_out0;
                if (abort) begin
                    state_d  = IDLE;
                    core_clr = 1'b1;
                end else if (cnt_empty) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (out_valid) begin
            ones0_d = ones0_d + (LENW+1)'(out0);
            ones1_d = ones1_d + (LENW+1)'(out1);
        end
    end

    // Sequencer state and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            fe_q    <= 1'b0;
            ones0_q <= '0;
            ones1_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            fe_q    <= fe_d;
            ones0_q <= ones0_d;
            ones1_q <= ones1_d;
        end
    end

    logic unused_full;
    assign unused_full = cnt_full;

endmodule
